pio_sm_ctrl: RTL and testbench



---
 rtl/pio_sm_ctrl.sv | 101 ++++++++++
 tb/tb_pio_sm_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pio_sm_ctrl.sv
// PIO cluster controller: shared 32x16 instruction memory, per-SM read ports, and
// a host command FSM that drives the per-SM enable, restart and immediate strobes.
module pio_sm_ctrl #(
  parameter int unsigned NUM_SM    = 4,
  parameter int unsigned MEM_DEPTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [NUM_SM-1:0]    cmd_mask,
  input  logic [4:0]           cmd_addr,
  input  logic [15:0]          cmd_data,
  input  logic [5*NUM_SM-1:0]  pc_all,
  output logic [16*NUM_SM-1:0] instr_all,
  output logic [NUM_SM-1:0]    en,
  output logic [NUM_SM-1:0]    restart,
  output logic [NUM_SM-1:0]    imm
);

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 16;

  localparam logic [1:0] OP_WRITE_IMEM = 2'd0;
  localparam logic [1:0] OP_SET_EN     = 2'd1;
  localparam logic [1:0] OP_RESTART    = 2'd2;
  localparam logic [1:0] OP_EXEC       = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RST  = 2'd1,
    EXE  = 2'd2,
    EXW  = 2'd3
  } state_t;

  state_t        state;
  logic [DW-1:0] exec_data;
  logic [DW-1:0] mem [MEM_DEPTH];

  // Command FSM, memory writes and strobe generation; strobes default low each cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      en        <= '0;
      restart   <= '0;
      imm       <= '0;
      exec_data <= '0;
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem[AW'(i)] <= '0;
      end
    end else begin
      restart <= '0;
      imm     <= '0;
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            case (cmd_op)
              OP_WRITE_IMEM: mem[cmd_addr] <= cmd_data;
              OP_SET_EN: begin
                en <= cmd_mask;
                // Sync restart only the machines that were off, so they start aligned.
                if (cmd_addr[0]) restart <= cmd_mask & ~en;
              end
              OP_RESTART: begin
                restart   <= cmd_mask;
                state     <= RST;
                cmd_ready <= 1'b0;
              end
              OP_EXEC: begin
                imm       <= cmd_mask;
                exec_data <= cmd_data;
                state     <= EXE;
                cmd_ready <= 1'b0;
              end
            endcase
          end
        end
        RST: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
        end
        EXE: state <= EXW;
        EXW: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

  // Per-SM read port; imm is high only in EXE, where it selects the forced word.
  always_comb begin
    instr_all = '0;
    for (int i = 0; i < NUM_SM; i++) begin
      instr_all[i*DW +: DW] = imm[i] ? exec_data : mem[pc_all[i*AW +: AW]];
    end
  end

endmodule

// File: tb/tb_pio_sm_ctrl.sv
// Scoreboard bench for pio_sm_ctrl: expectations are queued with each stimulus
// step and popped against the DUT outputs on the falling edge.
module tb_pio_sm_ctrl;

  localparam int SEL_INSTR = 0;
  localparam int SEL_EN    = 1;
  localparam int SEL_RST   = 2;
  localparam int SEL_IMM   = 3;
  localparam int SEL_READY = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [3:0]  cmd_mask;
  logic [4:0]  cmd_addr;
  logic [15:0] cmd_data;
  logic [19:0] pc_all;
  logic [63:0] instr_all;
  logic [3:0]  en;
  logic [3:0]  restart;
  logic [3:0]  imm;

  int n_checks = 0;
  int n_errors = 0;

  int          sel_q [$];
  string       tag_q [$];
  logic [63:0] exp_q [$];

  always #5 clk = ~clk;

  pio_sm_ctrl #(.NUM_SM(4), .MEM_DEPTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_mask  (cmd_mask),
    .cmd_addr  (cmd_addr),
    .cmd_data  (cmd_data),
    .pc_all    (pc_all),
    .instr_all (instr_all),
    .en        (en),
    .restart   (restart),
    .imm       (imm)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] observe(input int sel);
    case (sel)
      SEL_INSTR: return instr_all;
      SEL_EN:    return {60'd0, en};
      SEL_RST:   return {60'd0, restart};
      SEL_IMM:   return {60'd0, imm};
      default:   return {63'd0, cmd_ready};
    endcase
  endfunction

  task automatic sb_push(input int sel, input string tag, input logic [63:0] exp);
    sel_q.push_back(sel);
    tag_q.push_back(tag);
    exp_q.push_back(exp);
  endtask

  // Sample on the falling edge and compare everything queued for this cycle.
  task automatic sb_drain();
    @(negedge clk);
    while (exp_q.size() > 0) begin
      int          s;
      string       t;
      logic [63:0] e;
      s = sel_q.pop_front();
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      check(t, observe(s), e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic [1:0] op, input logic [3:0] mask,
                     input logic [4:0] addr, input logic [15:0] data);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_mask  = mask;
    cmd_addr  = addr;
    cmd_data  = data;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    cmd_mask  = 4'd0;
    cmd_addr  = 5'd0;
    cmd_data  = 16'd0;
    pc_all    = 20'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    sb_push(SEL_EN, "rst_en", 64'd0);
    sb_push(SEL_RST, "rst_restart", 64'd0);
    sb_push(SEL_IMM, "rst_imm", 64'd0);
    sb_push(SEL_READY, "rst_ready", 64'd1);
    sb_push(SEL_INSTR, "rst_instr", 64'd0);
    sb_drain();

    // Single write, read-after-write timing on lane 0
    step();
    cmd(2'd0, 4'hF, 5'd3, 16'hE081);
    pc_all = {5'd0, 5'd0, 5'd0, 5'd3};
    sb_push(SEL_INSTR, "wr_old_word", 64'h0);
    sb_push(SEL_READY, "wr_ready", 64'd1);
    sb_drain();
    step();
    cmd_valid = 1'b0;
    sb_push(SEL_INSTR, "wr_new_word", {48'h0, 16'hE081});
    sb_drain();

    // Back-to-back writes, one per cycle
    for (int i = 0; i < 4; i++) begin
      step();
      cmd(2'd0, 4'h0, 5'(i), 16'h1000 + 16'(i));
      sb_push(SEL_READY, $sformatf("b2b_ready%0d", i), 64'd1);
      sb_drain();
    end
    step();
    cmd_valid = 1'b0;
    pc_all = {5'd3, 5'd2, 5'd1, 5'd0};
    sb_push(SEL_INSTR, "b2b_readback", {16'h1003, 16'h1002, 16'h1001, 16'h1000});
    sb_drain();

    // SET_EN without sync, then with sync
    step();
    cmd(2'd1, 4'b0001, 5'd0, 16'h0);
    sb_drain();
    step();
    cmd_valid = 1'b0;
    sb_push(SEL_EN, "seten0_en", 64'b0001);
    sb_push(SEL_RST, "seten0_restart", 64'd0);
    sb_drain();
    step();
    cmd(2'd1, 4'b0111, 5'd1, 16'h0);
    sb_push(SEL_READY, "seten1_ready", 64'd1);
    sb_drain();
    step();
    cmd_valid = 1'b0;
    sb_push(SEL_EN, "seten1_en", 64'b0111);
    sb_push(SEL_RST, "seten1_restart", 64'b0110);
    sb_drain();
    step();
    sb_push(SEL_EN, "seten1_en_hold", 64'b0111);
    sb_push(SEL_RST, "seten1_restart_clr", 64'd0);
    sb_drain();

    // RESTART
    step();
    cmd(2'd2, 4'b1000, 5'd0, 16'h0);
    sb_drain();
    step();
    cmd_valid = 1'b0;
    sb_push(SEL_READY, "rstcmd_ready", 64'd0);
    sb_push(SEL_RST, "rstcmd_restart", 64'b1000);
    sb_push(SEL_EN, "rstcmd_en", 64'b0111);
    sb_drain();
    step();
    sb_push(SEL_READY, "rstcmd_ready_back", 64'd1);
    sb_push(SEL_RST, "rstcmd_restart_clr", 64'd0);
    sb_drain();

    // EXEC with a write held pending behind it
    step();
    cmd(2'd3, 4'b0010, 5'd0, 16'hA042);
    sb_push(SEL_IMM, "exec_imm_pre", 64'd0);
    sb_drain();
    step();
    cmd(2'd0, 4'h0, 5'd4, 16'hBEEF);
    sb_push(SEL_IMM, "exe_imm", 64'b0010);
    sb_push(SEL_READY, "exe_ready", 64'd0);
    sb_push(SEL_INSTR, "exe_instr", {16'h1003, 16'h1002, 16'hA042, 16'h1000});
    sb_drain();
    step();
    sb_push(SEL_IMM, "exw_imm", 64'd0);
    sb_push(SEL_READY, "exw_ready", 64'd0);
    sb_push(SEL_INSTR, "exw_instr", {16'h1003, 16'h1002, 16'h1001, 16'h1000});
    sb_drain();
    step();
    pc_all = {5'd3, 5'd2, 5'd1, 5'd4};
    sb_push(SEL_READY, "exec_ready_back", 64'd1);
    sb_push(SEL_INSTR, "pending_wr_not_done", {16'h1003, 16'h1002, 16'h1001, 16'h0000});
    sb_drain();
    step();
    cmd_valid = 1'b0;
    sb_push(SEL_INSTR, "pending_wr_done", {16'h1003, 16'h1002, 16'h1001, 16'hBEEF});
    sb_drain();

    // RESTART with empty mask: full sequence, no strobe
    step();
    cmd(2'd2, 4'b0000, 5'd0, 16'h0);
    sb_drain();
    step();
    cmd_valid = 1'b0;
    sb_push(SEL_READY, "rst0_ready", 64'd0);
    sb_push(SEL_RST, "rst0_restart", 64'd0);
    sb_drain();
    step();
    sb_push(SEL_READY, "rst0_ready_back", 64'd1);
    sb_drain();

    // Reset asserted during EXE
    step();
    cmd(2'd3, 4'b0100, 5'd0, 16'h1234);
    sb_drain();
    step();
    cmd_valid = 1'b0;
    sb_push(SEL_IMM, "exe2_imm", 64'b0100);
    sb_push(SEL_INSTR, "exe2_instr", {16'h1003, 16'h1234, 16'h1001, 16'hBEEF});
    sb_drain();
    reset = 1'b1;
    step();
    reset = 1'b0;
    sb_push(SEL_IMM, "rst_exe_imm", 64'd0);
    sb_push(SEL_EN, "rst_exe_en", 64'd0);
    sb_push(SEL_RST, "rst_exe_restart", 64'd0);
    sb_push(SEL_READY, "rst_exe_ready", 64'd1);
    sb_push(SEL_INSTR, "rst_exe_mem", 64'd0);
    sb_drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
